// File: rtl/event_capture_fifo.sv
// Event capture FIFO: filters decoder spike events, stamps them with the timestep bit,
// buffers them and hands them one at a time to the convolution engine.
module event_capture_fifo #(
  parameter int unsigned BITS_PER_COORDINATE = 8,
  parameter int unsigned IN_CHANNELS         = 2,
  parameter int unsigned IMG_WIDTH           = 32,
  parameter int unsigned IMG_HEIGHT          = 32,
  parameter int unsigned FIFO_DEPTH          = 16,
  parameter int unsigned CNT_BITS            = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  input  logic [BITS_PER_COORDINATE-1:0]                in_x,
  input  logic [BITS_PER_COORDINATE-1:0]                in_y,
  input  logic [IN_CHANNELS-1:0]                        in_spikes,
  output logic                                          in_ready,
  input  logic                                          timestep_tick,
  output logic                                          event_valid,
  output logic [2*BITS_PER_COORDINATE+IN_CHANNELS:0]    event_data,
  input  logic                                          conv_ready,
  input  logic                                          conv_ack,
  output logic [$clog2(FIFO_DEPTH):0]                   fifo_count,
  output logic [CNT_BITS-1:0]                           drop_full_cnt,
  output logic [CNT_BITS-1:0]                           drop_filt_cnt,
  output logic                                          busy
);

  localparam int unsigned EW = 1 + 2*BITS_PER_COORDINATE + IN_CHANNELS;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned CW = BITS_PER_COORDINATE + 1;
  localparam logic [CW-1:0] X_LIM    = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] Y_LIM    = CW'(IMG_HEIGHT);
  localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_WAIT_DONE,
    S_WAIT_READY
  } state_t;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          ts;
  state_t        state, state_d;
  logic          valid_d;
  logic [EW-1:0] data_d;
  logic          pop;
  logic          in_pass, full, push, drop_full, drop_filt;
  logic [NW-1:0] count_d;

  // Fullness is judged on pre-edge occupancy, so a same-cycle pop never makes room.
  assign full      = (fifo_count == FULL_CNT);
  assign in_pass   = (in_spikes != '0) && ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);
  assign push      = in_valid && in_pass && !full;
  assign drop_full = in_valid && in_pass && full;
  assign drop_filt = in_valid && !in_pass;
  assign count_d   = fifo_count + NW'(push) - NW'(pop);

  // Output handshake: present head, pop on ack, then wait for a full ready low/high cycle.
  always_comb begin
    state_d = state;
    valid_d = event_valid;
    data_d  = event_data;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        valid_d = 1'b0;
        if ((fifo_count != '0) && conv_ready) begin
          data_d  = mem[rd_ptr];
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (conv_ack) begin
          pop     = 1'b1;
          valid_d = 1'b0;
          state_d = conv_ready ? S_WAIT_DONE : S_WAIT_READY;
        end
      end
      S_WAIT_DONE: begin
        valid_d = 1'b0;
        if (!conv_ready) state_d = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        valid_d = 1'b0;
        if (conv_ready) state_d = S_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      event_valid <= 1'b0;
      event_data  <= '0;
    end else begin
      state       <= state_d;
      event_valid <= valid_d;
      event_data  <= data_d;
    end
  end

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {ts, in_x, in_y, in_spikes};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ts         <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_d;
      ts         <= ts ^ timestep_tick;
      in_ready   <= (count_d != FULL_CNT);
      busy       <= (count_d != '0) || (state_d != S_IDLE);
    end
  end

  // Saturating drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_full_cnt <= '0;
      drop_filt_cnt <= '0;
    end else begin
      if (drop_full && (drop_full_cnt != '1)) drop_full_cnt <= drop_full_cnt + CNT_BITS'(1);
      if (drop_filt && (drop_filt_cnt != '1)) drop_filt_cnt <= drop_filt_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_event_capture_fifo.sv
// Bench for event_capture_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_event_capture_fifo;

  localparam int B     = 8;
  localparam int C     = 2;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int DEPTH = 16;
  localparam int CNTB  = 16;
  localparam int EW    = 1 + 2*B + C;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [B-1:0]    in_x = '0;
  logic [B-1:0]    in_y = '0;
  logic [C-1:0]    in_spikes = '0;
  logic            in_ready;
  logic            timestep_tick = 1'b0;
  logic            event_valid;
  logic [EW-1:0]   event_data;
  logic            conv_ready = 1'b1;
  logic            conv_ack = 1'b0;
  logic [4:0]      fifo_count;
  logic [CNTB-1:0] drop_full_cnt;
  logic [CNTB-1:0] drop_filt_cnt;
  logic            busy;

  event_capture_fifo #(
    .BITS_PER_COORDINATE(B), .IN_CHANNELS(C), .IMG_WIDTH(IMG_W),
    .IMG_HEIGHT(IMG_H), .FIFO_DEPTH(DEPTH), .CNT_BITS(CNTB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_spikes(in_spikes), .in_ready(in_ready), .timestep_tick(timestep_tick),
    .event_valid(event_valid), .event_data(event_data), .conv_ready(conv_ready),
    .conv_ack(conv_ack), .fifo_count(fifo_count), .drop_full_cnt(drop_full_cnt),
    .drop_filt_cnt(drop_filt_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: delivery phases described in terms of what the convolution sees.
  localparam int P_IDLE = 0, P_SHOWN = 1, P_AWAIT_LOW = 2, P_AWAIT_HIGH = 3;
  logic [EW-1:0]   q[$];
  logic            m_ts = 1'b0;
  logic [CNTB-1:0] m_full_drops = '0;
  logic [CNTB-1:0] m_filt_drops = '0;
  int              m_phase = P_IDLE;
  logic            m_valid = 1'b0;
  logic [EW-1:0]   m_data = '0;
  bit              model_ok = 1'b0;
  bit              m_pass, m_was_full, m_pop;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ts = 1'b0; m_full_drops = '0; m_filt_drops = '0;
      m_phase = P_IDLE; m_valid = 1'b0; m_data = '0; model_ok = 1'b1;
    end else begin
      m_pass     = (in_spikes != '0) && (int'(in_x) < IMG_W) && (int'(in_y) < IMG_H);
      m_was_full = (q.size() == DEPTH);
      m_pop      = 1'b0;
      case (m_phase)
        P_IDLE: if (q.size() > 0 && conv_ready) begin
          m_data = q[0]; m_valid = 1'b1; m_phase = P_SHOWN;
        end
        P_SHOWN: if (conv_ack) begin
          m_pop = 1'b1; m_valid = 1'b0;
          m_phase = conv_ready ? P_AWAIT_LOW : P_AWAIT_HIGH;
        end
        P_AWAIT_LOW:  if (!conv_ready) m_phase = P_AWAIT_HIGH;
        default:      if (conv_ready) m_phase = P_IDLE;
      endcase
      if (in_valid && !m_pass && m_filt_drops != 16'hFFFF) m_filt_drops++;
      if (in_valid && m_pass && m_was_full && m_full_drops != 16'hFFFF) m_full_drops++;
      if (m_pop) void'(q.pop_front());
      if (in_valid && m_pass && !m_was_full) q.push_back({m_ts, in_x, in_y, in_spikes});
      m_ts = m_ts ^ timestep_tick;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_event_valid", 64'(event_valid), 64'(m_valid));
      if (m_valid) chk("m_event_data", 64'(event_data), 64'(m_data));
      chk("m_fifo_count", 64'(fifo_count), 64'(q.size()));
      chk("m_in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
      chk("m_busy", 64'(busy), 64'((q.size() != 0) || (m_phase != P_IDLE)));
      chk("m_drop_full", 64'(drop_full_cnt), 64'(m_full_drops));
      chk("m_drop_filt", 64'(drop_filt_cnt), 64'(m_filt_drops));
    end
  end

  // Presentation monitor: counts assertions and flags any made before ready cycled low/high.
  int   rises = 0;
  int   gated_viol = 0;
  logic prev_v = 1'b0;
  bit   gated = 1'b0, low_seen = 1'b0;
  always @(negedge clk) begin
    if (event_valid && !prev_v) begin
      rises++;
      if (gated) gated_viol++;
    end
    if (gated && !conv_ready) low_seen = 1'b1;
    if (gated && low_seen && conv_ready) begin gated = 1'b0; low_seen = 1'b0; end
    if (event_valid && conv_ack) begin gated = 1'b1; low_seen = 1'b0; end
    prev_v = event_valid;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input int x, input int y, input int s);
    in_valid = 1'b1; in_x = B'(x); in_y = B'(y); in_spikes = C'(s);
  endtask

  task automatic serve(input int hold, output logic [EW-1:0] d);
    int n;
    d = '0; n = 0;
    conv_ready = 1'b1;
    while (!event_valid && n < 20) begin cyc(); n++; end
    if (!event_valid) chk("serve_timeout", 64'(event_valid), 64'd1);
    else begin
      d = event_data;
      conv_ack = 1'b1; cyc(); conv_ack = 1'b0;
      conv_ready = 1'b0;
      repeat (hold) cyc();
      conv_ready = 1'b1;
    end
  endtask

  logic [EW-1:0] d0, d1, d2;
  int r0;

  initial begin
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_event_valid", 64'(event_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_counters", 64'({drop_full_cnt, drop_filt_cnt}), 64'd0);

    // Single event: valid two edges after push, data {0,5,7,01}
    push(5, 7, 1); cyc(); in_valid = 1'b0;
    chk("single_not_yet", 64'(event_valid), 64'd0);
    cyc();
    chk("single_valid", 64'(event_valid), 64'd1);
    chk("single_data", 64'(event_data), 64'd5149);
    conv_ack = 1'b1; cyc(); conv_ack = 1'b0;
    chk("single_ack_valid", 64'(event_valid), 64'd0);
    chk("single_ack_count", 64'(fifo_count), 64'd0);
    conv_ready = 1'b0; cyc(); conv_ready = 1'b1; cyc();
    chk("single_idle_busy", 64'(busy), 64'd0);

    // Filter drops
    push(1, 1, 0); cyc();
    push(32, 0, 1); cyc();
    push(0, 40, 1); cyc();
    in_valid = 1'b0; cyc();
    chk("filt_cnt", 64'(drop_filt_cnt), 64'd3);
    chk("filt_count", 64'(fifo_count), 64'd0);
    chk("filt_valid", 64'(event_valid), 64'd0);

    // Full: 18 pushes into 16 entries, then a push coincident with the first pop
    conv_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin push(i, i, 2); cyc(); end
    in_valid = 1'b0;
    chk("full_count", 64'(fifo_count), 64'd16);
    chk("full_drops", 64'(drop_full_cnt), 64'd2);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    conv_ready = 1'b1; cyc();
    chk("full_head_data", 64'(event_data), 64'd2);
    conv_ack = 1'b1; push(1, 1, 1); cyc(); conv_ack = 1'b0; in_valid = 1'b0;
    chk("full_pop_push_drops", 64'(drop_full_cnt), 64'd3);
    chk("full_pop_push_count", 64'(fifo_count), 64'd15);
    conv_ready = 1'b0; cyc();
    for (int i = 0; i < 15; i++) serve(1, d0);
    cyc(); cyc();
    chk("full_drained", 64'(fifo_count), 64'd0);

    // Timestep stamping: A, tick+B, C
    conv_ready = 1'b0;
    push(1, 1, 1); cyc();
    push(2, 2, 1); timestep_tick = 1'b1; cyc(); timestep_tick = 1'b0;
    push(3, 3, 1); cyc(); in_valid = 1'b0;
    serve(1, d0); serve(1, d1); serve(1, d2);
    chk("ts_A", 64'(d0), 64'd1029);
    chk("ts_B", 64'(d1), 64'd2057);
    chk("ts_C", 64'(d2), 64'd265229);

    // Handshake ordering with a slow convolution and a spurious ack in IDLE
    conv_ready = 1'b0; cyc(); cyc();
    for (int i = 0; i < 3; i++) begin push(10 + i, 3, 3); cyc(); end
    in_valid = 1'b0;
    conv_ack = 1'b1; cyc(); conv_ack = 1'b0; cyc();
    chk("spurious_ack_count", 64'(fifo_count), 64'd3);
    r0 = rises;
    for (int i = 0; i < 3; i++) serve(20, d0);
    repeat (5) cyc();
    chk("hs_presentations", 64'(rises - r0), 64'd3);
    chk("hs_gated_viol", 64'(gated_viol), 64'd0);

    // Reset in the middle of a presentation with 5 buffered events
    conv_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin push(i + 1, 1, 1); cyc(); end
    in_valid = 1'b0; conv_ready = 1'b1; cyc();
    chk("rst_mid_presented", 64'(event_valid), 64'd1);
    rst = 1'b1; conv_ack = 1'b1; cyc(); rst = 1'b0; conv_ack = 1'b0;
    chk("rst_mid_valid", 64'(event_valid), 64'd0);
    chk("rst_mid_count", 64'(fifo_count), 64'd0);
    chk("rst_mid_counters", 64'({drop_full_cnt, drop_filt_cnt}), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_data", 64'(event_data), 64'd0);
    push(4, 4, 3); cyc(); in_valid = 1'b0; cyc();
    chk("rst_mid_ts_cleared", 64'(event_data), 64'd4115);
    conv_ack = 1'b1; cyc(); conv_ack = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/event_capture_fifo.md
Name: event_capture_fifo

Overview:
- Producer end of the convolution event interface. It receives spike events from the upstream input decoder, filters and buffers them, and stamps each with the current timestep bit.
- It presents one event at a time to Convolution2d using the event_valid / conv_ready / conv_ack handshake. Each event is released only when the convolution engine is idle.
- It sits between the input event decoder and Convolution2d in the convolution layer.

Parameters:
- BITS_PER_COORDINATE, 8, width of x and y coordinates.
- IN_CHANNELS, 2, number of input spike channels.
- IMG_WIDTH, 32, valid x range 0..IMG_WIDTH-1.
- IMG_HEIGHT, 32, valid y range 0..IMG_HEIGHT-1.
- FIFO_DEPTH, 16, buffer entries; must be a power of 2 and at least 2.
- CNT_BITS, 16, width of the status counters.

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream event strobe, one event per cycle. Upstream has no backpressure.
- in_x  in  BITS_PER_COORDINATE  event x.
- in_y  in  BITS_PER_COORDINATE  event y.
- in_spikes  in  IN_CHANNELS  per-channel spike mask.
- in_ready  out  1  !full; informational only.
- timestep_tick  in  1  one-cycle pulse marking a timestep boundary.
- event_valid  out  1  head event is presented to the convolution.
- event_data  out  1+2*BITS_PER_COORDINATE+IN_CHANNELS  packed {timestep, x, y, spikes}, MSB first.
- conv_ready  in  1  convolution idle and able to accept an event.
- conv_ack  in  1  one-cycle pulse; the convolution has latched event_data.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_full_cnt  out  CNT_BITS  events dropped because the FIFO was full; saturating.
- drop_filt_cnt  out  CNT_BITS  events dropped by the filter; saturating.
- busy  out  1  FIFO non-empty or output FSM not in IDLE.

Behaviour:
- Reset: when rst=1 at a clock edge, all of the following are cleared.
  - FIFO pointers and count go to 0; event_valid goes to 0; event_data goes to 0.
  - The timestep bit goes to 0; both counters go to 0; the FSM goes to IDLE.
  - Reset applies mid-handshake: in-flight and buffered events are discarded, and a conv_ack in the reset cycle is ignored.
- Filter, evaluated in the in_valid cycle:
  - The event is dropped if in_spikes==0, in_x>=IMG_WIDTH or in_y>=IMG_HEIGHT.
  - A dropped event increments drop_filt_cnt.
- Push:
  - A filtered-valid event is written at the edge if the FIFO was not full at the start of the cycle; otherwise drop_full_cnt increments.
  - A pop in the same cycle does not free space for that push; full is evaluated on pre-edge state.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave count unchanged.
- Timestep stamping:
  - The internal ts bit toggles on timestep_tick.
  - An event pushed in the same cycle as a tick carries the old ts.
  - Stored events keep their stamp.
- Counters saturate at 2^CNT_BITS-1 and never wrap.
- Pointers wrap modulo FIFO_DEPTH.
- Output FSM, with registered outputs:
  - IDLE: event_valid=0. If the FIFO is non-empty and conv_ready=1, load the head into event_data, set event_valid=1 and go to PRESENT. Minimum latency from an empty-FIFO push to event_valid high is 2 cycles.
  - PRESENT: event_valid=1 and event_data is held stable. On conv_ack=1, pop the head, set event_valid=0 next cycle and go to WAIT_DONE. conv_ready falling without an ack does not withdraw the event.
  - WAIT_DONE: event_valid=0. Wait for conv_ready=0, then go to WAIT_READY. If conv_ready is already 0 in the ack cycle, go directly to WAIT_READY.
  - WAIT_READY: event_valid=0. When conv_ready=1, go to IDLE.
  - conv_ack received outside PRESENT is ignored: no pop and no state change.
- Back-to-back events: event_valid stays low for at least one full cycle after each ack, so the convolution never sees the same event twice.

Test Plan:
- Single event: IMG 32x32, push (x=5,y=7,spikes=2'b01), conv_ready=1 -> event_valid high 2 cycles later with event_data={0,5,7,01}. Ack in cycle N -> event_valid=0 at N+1, fifo_count=0.
- Filter: push spikes=0, then x=32, then y=40 -> no FIFO writes, drop_filt_cnt=3, event_valid stays 0.
- Full: FIFO_DEPTH=16, conv_ready=0, push 18 valid events -> fifo_count=16, drop_full_cnt=2, in_ready=0. Push coincident with the first pop when full -> still dropped, drop_full_cnt=3.
- Timestep: push A, tick plus push B in the same cycle, push C -> A.ts=0, B.ts=0, C.ts=1, delivered in order A,B,C.
- Handshake ordering: 3 buffered events, convolution model holds conv_ready=0 for 20 cycles after each ack -> exactly 3 event_valid assertions, none while conv_ready=0 after an ack. A spurious conv_ack in IDLE leaves fifo_count unchanged.
- Reset mid-PRESENT: rst=1 for 1 cycle with 5 buffered events -> next cycle event_valid=0, fifo_count=0, counters=0, ts=0, busy=0.
